// File: rtl/lif_neuron_array.sv
// Time-multiplexed array of leaky integrate-and-fire neurons sharing one update datapath.
// Synaptic events integrate in IDLE; a timestep tick triggers a one-neuron-per-cycle leak sweep.
module lif_neuron_array #(
    parameter int NUM_NEURONS     = 16,
    parameter int ID_WIDTH        = 4,
    parameter int DATA_WIDTH      = 16,
    parameter int WEIGHT_WIDTH    = 8,
    parameter int THRESHOLD_WIDTH = 16,
    parameter int LEAK_WIDTH      = 8,
    parameter int REFRAC_WIDTH    = 8,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       syn_valid,
    output logic                       syn_ready,
    input  logic [ID_WIDTH-1:0]        syn_neuron_id,
    input  logic [WEIGHT_WIDTH-1:0]    syn_weight,
    input  logic                       syn_excitatory,
    input  logic                       timestep_tick,
    input  logic [THRESHOLD_WIDTH-1:0] threshold,
    input  logic [LEAK_WIDTH-1:0]      leak_rate,
    input  logic                       leak_mode,
    input  logic [REFRAC_WIDTH-1:0]    refractory_period,
    input  logic                       reset_potential_en,
    input  logic [DATA_WIDTH-1:0]      reset_potential,
    output logic                       spike_valid,
    input  logic                       spike_ready,
    output logic [ID_WIDTH-1:0]        spike_neuron_id,
    output logic                       busy,
    output logic [31:0]                spike_count,
    output logic                       fifo_overflow,
    input  logic [ID_WIDTH-1:0]        mon_neuron_id,
    output logic [DATA_WIDTH-1:0]      mon_membrane,
    output logic [REFRAC_WIDTH-1:0]    mon_refrac
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [ID_WIDTH-1:0] LAST_IDX = ID_WIDTH'(NUM_NEURONS - 1);

    typedef enum logic [0:0] {IDLE, SWEEP} state_t;

    state_t                  state, state_next;
    logic                    tick_pending;
    logic                    sweep_start;
    logic [ID_WIDTH-1:0]     idx;

    logic [DATA_WIDTH-1:0]   v [NUM_NEURONS];
    logic [REFRAC_WIDTH-1:0] r [NUM_NEURONS];

    logic                    accept;
    logic [ID_WIDTH-1:0]     tgt;
    logic                    tgt_in_range;
    logic [DATA_WIDTH-1:0]   cur_v;
    logic [REFRAC_WIDTH-1:0] cur_r;
    logic [DATA_WIDTH-1:0]   w_ext, leak_ext, thr_ext;
    logic [DATA_WIDTH:0]     sum_ext;
    logic [DATA_WIDTH-1:0]   integrated;
    logic                    wr_en;
    logic [DATA_WIDTH-1:0]   wr_v;
    logic [REFRAC_WIDTH-1:0] wr_r;
    logic                    spike;

    logic [ID_WIDTH-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [PTR_W:0]          fifo_cnt;
    logic                    fifo_full, pop, push_ok;

    // ---------------- control FSM ----------------
    always_comb begin
        state_next  = state;
        sweep_start = 1'b0;
        case (state)
            IDLE: begin
                if (enable && tick_pending) begin
                    state_next  = SWEEP;
                    sweep_start = 1'b1;
                end
            end
            SWEEP: begin
                if (idx == LAST_IDX) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            tick_pending <= 1'b0;
            idx          <= '0;
        end else begin
            state        <= state_next;
            // A tick arriving on the sweep-entry cycle must stay pending for the next sweep.
            tick_pending <= timestep_tick | (tick_pending & ~sweep_start);
            if (sweep_start)
                idx <= '0;
            else if (state == SWEEP)
                idx <= idx + 1'b1;
        end
    end

    assign syn_ready = ~rst & (state == IDLE) & enable & ~tick_pending & ~timestep_tick;
    assign busy      = tick_pending | (state == SWEEP);
    assign accept    = syn_valid & syn_ready;

    // ---------------- shared neuron datapath ----------------
    assign tgt          = (state == SWEEP) ? idx : syn_neuron_id;
    assign tgt_in_range = 32'(tgt) < 32'(NUM_NEURONS);
    assign cur_v        = tgt_in_range ? v[tgt] : '0;
    assign cur_r        = tgt_in_range ? r[tgt] : '0;
    assign w_ext        = DATA_WIDTH'(syn_weight);
    assign leak_ext     = DATA_WIDTH'(leak_rate);
    assign thr_ext      = DATA_WIDTH'(threshold);
    assign sum_ext      = {1'b0, cur_v} + {1'b0, w_ext};

    always_comb begin
        if (syn_excitatory)
            integrated = sum_ext[DATA_WIDTH] ? '1 : sum_ext[DATA_WIDTH-1:0];
        else
            integrated = (cur_v < w_ext) ? '0 : cur_v - w_ext;
    end

    always_comb begin
        wr_en = 1'b0;
        wr_v  = cur_v;
        wr_r  = cur_r;
        spike = 1'b0;
        if (state == SWEEP) begin
            wr_en = 1'b1;
            if (cur_r != '0)
                wr_r = cur_r - 1'b1;
            else if (!leak_mode)
                wr_v = (cur_v < leak_ext) ? '0 : cur_v - leak_ext;
            else
                wr_v = cur_v - (cur_v >> leak_rate[3:0]);
        end else if (accept && tgt_in_range && cur_r == '0) begin
            wr_en = 1'b1;
            wr_v  = integrated;
            if (integrated >= thr_ext) begin
                spike = 1'b1;
                wr_v  = reset_potential_en ? reset_potential : '0;
                wr_r  = refractory_period;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
                v[i] <= '0;
                r[i] <= '0;
            end
        end else if (wr_en) begin
            for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
                if (32'(tgt) == i) begin
                    v[i] <= wr_v;
                    r[i] <= wr_r;
                end
            end
        end
    end

    // ---------------- output spike FIFO ----------------
    assign spike_valid     = (fifo_cnt != '0);
    assign spike_neuron_id = fifo_mem[rd_ptr];
    assign fifo_full       = (fifo_cnt == (PTR_W+1)'(FIFO_DEPTH));
    assign pop             = spike_valid & spike_ready;
    assign push_ok         = spike & (~fifo_full | pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_cnt      <= '0;
            fifo_overflow <= 1'b0;
            spike_count   <= '0;
        end else begin
            if (push_ok) begin
                fifo_mem[wr_ptr] <= tgt;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (spike & fifo_full & ~pop) fifo_overflow <= 1'b1;
            if (spike) spike_count <= spike_count + 32'd1;
        end
    end

    // ---------------- monitor readback ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mon_membrane <= '0;
            mon_refrac   <= '0;
        end else if (32'(mon_neuron_id) < 32'(NUM_NEURONS)) begin
            mon_membrane <= v[mon_neuron_id];
            mon_refrac   <= r[mon_neuron_id];
        end else begin
            mon_membrane <= '0;
            mon_refrac   <= '0;
        end
    end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Scoreboarded bench for lif_neuron_array: an arithmetic neuron model predicts spikes and state,
// expected spike IDs are queued and checked by an independent output monitor.
module tb_lif_neuron_array;

    localparam int N  = 16;
    localparam int FD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        syn_valid = 1'b0;
    logic        syn_ready;
    logic [3:0]  syn_neuron_id = '0;
    logic [7:0]  syn_weight = '0;
    logic        syn_excitatory = 1'b1;
    logic        timestep_tick = 1'b0;
    logic [15:0] threshold = '0;
    logic [7:0]  leak_rate = '0;
    logic        leak_mode = 1'b0;
    logic [7:0]  refractory_period = '0;
    logic        reset_potential_en = 1'b0;
    logic [15:0] reset_potential = '0;
    logic        spike_valid;
    logic        spike_ready = 1'b1;
    logic [3:0]  spike_neuron_id;
    logic        busy;
    logic [31:0] spike_count;
    logic        fifo_overflow;
    logic [3:0]  mon_neuron_id = '0;
    logic [15:0] mon_membrane;
    logic [7:0]  mon_refrac;

    always #5 clk = ~clk;

    lif_neuron_array #(
        .NUM_NEURONS(N), .ID_WIDTH(4), .DATA_WIDTH(16), .WEIGHT_WIDTH(8),
        .THRESHOLD_WIDTH(16), .LEAK_WIDTH(8), .REFRAC_WIDTH(8), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .syn_valid(syn_valid), .syn_ready(syn_ready), .syn_neuron_id(syn_neuron_id),
        .syn_weight(syn_weight), .syn_excitatory(syn_excitatory),
        .timestep_tick(timestep_tick), .threshold(threshold), .leak_rate(leak_rate),
        .leak_mode(leak_mode), .refractory_period(refractory_period),
        .reset_potential_en(reset_potential_en), .reset_potential(reset_potential),
        .spike_valid(spike_valid), .spike_ready(spike_ready), .spike_neuron_id(spike_neuron_id),
        .busy(busy), .spike_count(spike_count), .fifo_overflow(fifo_overflow),
        .mon_neuron_id(mon_neuron_id), .mon_membrane(mon_membrane), .mon_refrac(mon_refrac)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int ref_v [N];
    int ref_r [N];
    longint ref_count = 0;
    int ref_ovf = 0;
    int exp_q [$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every handshake beat is matched against the oldest expected spike
    always @(negedge clk) begin
        if (!rst && spike_valid && spike_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spike_unexpected: got id %0d, expected no spike", spike_neuron_id);
            end else begin
                chk("spike_id", spike_neuron_id, exp_q.pop_front());
            end
        end
    end

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            ref_v[i] = 0;
            ref_r[i] = 0;
        end
        ref_count = 0;
        ref_ovf   = 0;
        exp_q.delete();
    endfunction

    function automatic void model_event(input int id, input int w, input bit exc);
        int nv;
        if (id >= N || ref_r[id] != 0) return;
        nv = exc ? ref_v[id] + w : ref_v[id] - w;
        if (nv > 65535) nv = 65535;
        if (nv < 0) nv = 0;
        if (nv >= int'(threshold)) begin
            ref_v[id] = reset_potential_en ? int'(reset_potential) : 0;
            ref_r[id] = int'(refractory_period);
            ref_count++;
            if (exp_q.size() == FD && !(spike_ready && exp_q.size() > 0))
                ref_ovf = 1;
            else
                exp_q.push_back(id);
        end else begin
            ref_v[id] = nv;
        end
    endfunction

    function automatic void model_sweep();
        for (int i = 0; i < N; i++) begin
            if (ref_r[i] != 0)
                ref_r[i]--;
            else if (!leak_mode)
                ref_v[i] = (ref_v[i] < int'(leak_rate)) ? 0 : ref_v[i] - int'(leak_rate);
            else
                ref_v[i] = ref_v[i] - (ref_v[i] >> (int'(leak_rate) % 16));
        end
    endfunction

    task automatic send_event(input int id, input int w, input bit exc);
        int n;
        syn_neuron_id  = 4'(id);
        syn_weight     = 8'(w);
        syn_excitatory = exc;
        syn_valid      = 1'b1;
        #1;
        n = 0;
        while (!syn_ready && n < 100) begin
            step();
            #1;
            n++;
        end
        if (!syn_ready) begin
            checks++;
            errors++;
            $display("FAIL event_timeout: syn_ready never rose, got 0, expected 1");
        end else begin
            model_event(id, w, exc);
            step();
        end
        syn_valid = 1'b0;
    endtask

    task automatic do_tick();
        int n;
        timestep_tick = 1'b1;
        model_sweep();
        step();
        timestep_tick = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            step();
        end
        chk("busy_cycles", n, N + 1);
    endtask

    task automatic check_neuron(input int id);
        mon_neuron_id = 4'(id);
        step();
        chk($sformatf("mon_v[%0d]", id), mon_membrane, ref_v[id]);
        chk($sformatf("mon_r[%0d]", id), mon_refrac, ref_r[id]);
    endtask

    task automatic check_globals();
        chk("spike_count", spike_count, ref_count);
        chk("fifo_overflow", fifo_overflow, ref_ovf);
    endtask

    task automatic drain();
        spike_ready = 1'b1;
        repeat (FD + 2) step();
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_syn_ready"}, syn_ready, 0);
        chk({tag, "_spike_valid"}, spike_valid, 0);
        chk({tag, "_spike_id"}, spike_neuron_id, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_spike_count"}, spike_count, 0);
        chk({tag, "_overflow"}, fifo_overflow, 0);
        chk({tag, "_mon_v"}, mon_membrane, 0);
        chk({tag, "_mon_r"}, mon_refrac, 0);
    endtask

    initial begin
        int n;
        model_reset();
        repeat (3) step();
        check_reset_outputs("reset");
        rst = 1'b0;
        step();

        // Basic integrate and fire on neuron 3
        enable = 1'b1;
        threshold = 16'h0040;
        refractory_period = 8'd5;
        send_event(3, 8'h20, 1'b1);
        check_neuron(3);
        chk("setup_v_first", mon_membrane, 16'h0020);
        send_event(3, 8'h20, 1'b1);
        chk("setup_spike_valid", spike_valid, 1);
        chk("setup_spike_id", spike_neuron_id, 3);
        check_neuron(3);
        check_globals();

        // Refractory: ignored event, then recovery after five ticks
        send_event(3, 8'h20, 1'b1);
        check_neuron(3);
        repeat (5) do_tick();
        check_neuron(3);
        send_event(3, 8'h20, 1'b1);
        check_neuron(3);

        // Subtractive and multiplicative leak
        threshold = 16'h0100;
        refractory_period = 8'd0;
        send_event(5, 8'h30, 1'b1);
        send_event(6, 8'h05, 1'b1);
        leak_rate = 8'h08;
        do_tick();
        check_neuron(5);
        chk("leak_sub_value", mon_membrane, 16'h0028);
        check_neuron(6);
        leak_mode = 1'b1;
        leak_rate = 8'd3;
        send_event(7, 8'h80, 1'b1);
        do_tick();
        check_neuron(7);
        chk("leak_shift_value", mon_membrane, 16'h0070);
        leak_mode = 1'b0;
        leak_rate = 8'd0;

        // Saturation via reset potential, then inhibition floor
        threshold = 16'h0010;
        reset_potential_en = 1'b1;
        reset_potential = 16'hFFF0;
        send_event(8, 8'h20, 1'b1);
        check_neuron(8);
        threshold = 16'hFFFF;
        reset_potential_en = 1'b0;
        send_event(8, 8'h20, 1'b1);
        check_neuron(8);
        send_event(9, 8'h10, 1'b1);
        send_event(9, 8'h20, 1'b0);
        check_neuron(9);
        check_globals();
        drain();

        // FIFO overflow with output stalled
        spike_ready = 1'b0;
        threshold = 16'h0010;
        for (int i = 10; i < 15; i++) send_event(i, 8'h20, 1'b1);
        check_globals();
        chk("ovf_spike_valid", spike_valid, 1);
        chk("ovf_head_id", spike_neuron_id, 10);
        drain();

        // Randomized mix of events and ticks
        for (int k = 0; k < 80; k++) begin
            threshold          = 16'($urandom_range(16'h20, 16'h180));
            refractory_period  = 8'($urandom_range(0, 3));
            reset_potential_en = 1'($urandom_range(0, 1));
            reset_potential    = 16'($urandom_range(0, 16'h1F));
            spike_ready        = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 2) begin
                leak_mode = 1'($urandom_range(0, 1));
                leak_rate = 8'($urandom_range(0, 255));
                do_tick();
            end else begin
                send_event($urandom_range(0, N - 1), $urandom_range(0, 255), 1'($urandom_range(0, 3) != 0));
            end
            check_neuron($urandom_range(0, N - 1));
            check_globals();
        end
        drain();

        // Tick and event collide: event waits for the whole sweep
        leak_mode = 1'b0;
        leak_rate = 8'd1;
        threshold = 16'hFFFF;
        refractory_period = 8'd0;
        syn_neuron_id = 4'd2;
        syn_weight = 8'h10;
        syn_excitatory = 1'b1;
        syn_valid = 1'b1;
        timestep_tick = 1'b1;
        #1;
        chk("collision_ready", syn_ready, 0);
        model_sweep();
        step();
        timestep_tick = 1'b0;
        #1;
        n = 0;
        while (!syn_ready && n < 100) begin
            step();
            #1;
            n++;
        end
        chk("collision_wait", n, N + 1);
        chk("collision_busy", busy, 0);
        model_event(2, 8'h10, 1'b1);
        step();
        syn_valid = 1'b0;
        check_neuron(2);

        // Reset in the middle of a sweep
        timestep_tick = 1'b1;
        step();
        timestep_tick = 1'b0;
        repeat (3) step();
        chk("midsweep_busy", busy, 1);
        rst = 1'b1;
        step();
        model_reset();
        check_reset_outputs("midsweep");
        rst = 1'b0;
        step();
        check_neuron(2);
        check_neuron(5);
        check_globals();

        repeat (4) step();
        chk("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

endmodule
